// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits needed to count 0..width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full-adder cell; the carry flop lives in the parent.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one bit per clock with a start/busy/done handshake.
// Define SERIAL_ADDSUB_OVF_EN to compute the signed-overflow flag; otherwise ovf is tied to 0.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             s_bit,
    output logic             s_valid
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s, fa_co;
    logic             load, last;

    serial_fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign last = (state == SHIFT) && (cnt == LAST);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A's vacated MSBs collect the sum bits, so it ends up holding the result word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            if (load) begin
                a_sr  <= a;
                b_sr  <= (op == OP_SUB) ? ~b : b;
                carry <= op;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                a_sr  <= {fa_s, a_sr[WIDTH-1:1]};
                b_sr  <= b_sr >> 1;
                carry <= fa_co;
                cnt   <= cnt + 1'b1;
            end
            if (last) begin
                result <= {fa_s, a_sr[WIDTH-1:1]};
                cout   <= fa_co;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // During the last cycle the carry register holds the carry into the MSB.
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= carry ^ fa_co;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);
    assign s_valid = busy;
    assign s_bit   = busy & fa_s;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor with a parallel load/unload and a start/busy/done handshake. Operands of WIDTH bits are loaded in parallel and processed LSB-first through a single full-adder cell with a registered carry, one bit per clock. The result word, carry/borrow and an optional signed-overflow flag are presented in parallel. A per-bit serial output stream is also provided. The block succeeds the fixed 1-bit-stream serial adder and gives arithmetic sub-units a framed, multi-width, add/sub-capable serial datapath.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..64
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled on clk rising edge, accepted when idle
- op  in  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse: result/cout/ovf valid
- result  out  WIDTH  sum/difference modulo 2^WIDTH; held until next accepted start
- cout  out  1  add: carry out; sub: 1 = no borrow (a >= b unsigned)
- ovf  out  1  signed (two's complement) overflow; see Configuration
- s_bit  out  1  current result bit, LSB first
- s_valid  out  1  s_bit qualifier, high each processing cycle

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - start=1 loads the A shift register with a.
  - Loads the B shift register with b, or ~b when op=1.
  - Loads carry with op (0 for add, 1 for subtract).
  - Clears bit counter to 0 and goes to SHIFT.
- SHIFT, each cycle:
  - sum = A[0]^B[0]^carry.
  - Next carry = majority(A[0],B[0],carry).
  - sum shifts into the result register MSB side; A and B shift right.
  - Counter increments.
  - When counter = WIDTH-1, go to DONE.
- DONE:
  - done=1 for one cycle; cout = final carry.
  - Next state is IDLE, or SHIFT if start=1 (back-to-back accept, same load rules).
- start in SHIFT is ignored. No queuing.
- Changes to a/b/op after acceptance have no effect.
- result, cout and ovf update only on the edge entering DONE. They hold otherwise, including through IDLE.
- s_bit = sum of the current SHIFT cycle. s_valid = (state == SHIFT).

## Timing
- Reset values: busy 0, done 0, result 0, cout 0, ovf 0, s_valid 0, s_bit 0. The counter and shift registers also clear to 0.
- Reset is asynchronous. Asserting rst_n mid-SHIFT aborts the operation immediately with the reset values above. No done pulse is produced for the aborted operation.
- Latency: start accepted at edge k.
  - busy is high during cycles k..k+WIDTH-1.
  - done is high in cycle k+WIDTH, i.e. after edge k+WIDTH.
- Throughput: one operation per WIDTH+1 cycles when start is held or re-asserted in the DONE cycle.
- busy and done are never high together.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined:
  - A flop captures the carry into the MSB (carry before the last SHIFT cycle).
  - ovf = carry_into_msb ^ carry_out, registered with result.
- Not defined: ovf is tied to 0 and no extra flop exists.

## Structure
- Package serial_addsub_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - op encodings OP_ADD=1'b0 and OP_SUB=1'b1;
  - counter width as $clog2(WIDTH) via a function.
- Sub-module serial_fa_cell: combinational full adder (a, b, cin -> s, cout). The carry flop stays in the parent.

## Test plan
- WIDTH=4, reset then add 9+7:
  - done 4 cycles after start, result=0, cout=1, ovf=0.
  - s_bit sequence LSB-first 0,0,0,0.
- WIDTH=4, sub 3-5: result=14 (1110), cout=0 (borrow), ovf=0.
- WIDTH=4, add 7+1: result=8, cout=0, ovf=1 with macro, 0 without.
- WIDTH=8:
  - sub 200-100: result=100, cout=1.
  - start re-asserted in DONE cycle with add 255+1: result=0, cout=1, done 8 cycles later.
  - start pulses during busy are ignored.
- Reset mid-operation: rst_n low during SHIFT bit 2 gives busy=0, done=0, result=0 asynchronously. After release, a new add 5+6 gives 11.
- Exhaustive WIDTH=4: all 256 operand pairs, both ops, compared against a behavioural model (result, cout, ovf).
